// File: rtl/huff_encoder_param_if.sv
// Stream bundle for the parametrised Huffman encoder: the (symbol, frequency)
// input stream and the (symbol, code, length) output record stream.
interface huff_encoder_param_if #(
   parameter int unsigned SYM_W  = 8,
   parameter int unsigned FREQ_W = 4,
   parameter int unsigned CODE_W = 3,
   parameter int unsigned LEN_W  = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [SYM_W-1:0]  in_sym;
   logic [FREQ_W-1:0] in_freq;
   logic              out_valid;
   logic              out_ready;
   logic [SYM_W-1:0]  out_sym;
   logic [CODE_W-1:0] out_code;
   logic [LEN_W-1:0]  out_len;
   logic              out_last;

   // Upstream/downstream side: drives pairs in and accepts records.
   modport master (
      output in_valid, in_sym, in_freq, out_ready,
      input  in_ready, out_valid, out_sym, out_code, out_len, out_last
   );

   // Encoder side.
   modport slave (
      input  in_valid, in_sym, in_freq, out_ready,
      output in_ready, out_valid, out_sym, out_code, out_len, out_last
   );
endinterface

// File: rtl/huff_encoder_param.sv
// Iterative Huffman encoder. Loads NSYM (symbol, frequency) pairs, merges the
// two lightest active nodes once per cycle, assigns codes from the root down,
// then streams one (symbol, code, length) record per symbol in load order.
module huff_encoder_param #(
   parameter int unsigned NSYM   = 4,
   parameter int unsigned SYM_W  = 8,
   parameter int unsigned FREQ_W = 4,
   parameter int unsigned CODE_W = NSYM - 1,
   parameter int unsigned LEN_W  = $clog2(CODE_W + 1)
) (
   input  logic                clk,
   input  logic                reset,
   huff_encoder_param_if.slave bus,
   output logic                busy
);
   localparam int unsigned NNODE  = 2 * NSYM - 1;
   localparam int unsigned IDX_W  = $clog2(NNODE);
   localparam int unsigned LEAF_W = $clog2(NSYM);
   localparam int unsigned W_W    = FREQ_W + $clog2(NSYM);
   localparam logic [IDX_W-1:0] LastLeaf = IDX_W'(NSYM - 1);
   localparam logic [IDX_W-1:0] FirstInt = IDX_W'(NSYM);
   localparam logic [IDX_W-1:0] Root     = IDX_W'(NNODE - 1);

   typedef enum logic [1:0] {StLoad, StBuild, StAssign, StEmit} state_e;

   state_e            state_q, state_d;
   // Load slot, node being created, node being assigned, or leaf being emitted.
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [LEAF_W-1:0] leaf;

   logic [W_W-1:0]    w_q    [NNODE];
   logic [W_W-1:0]    w_d    [NNODE];
   logic              act_q  [NNODE];
   logic              act_d  [NNODE];
   logic [IDX_W-1:0]  par_q  [NNODE];
   logic [IDX_W-1:0]  par_d  [NNODE];
   logic              br_q   [NNODE];
   logic              br_d   [NNODE];
   logic [CODE_W-1:0] code_q [NNODE];
   logic [CODE_W-1:0] code_d [NNODE];
   logic [LEN_W-1:0]  len_q  [NNODE];
   logic [LEN_W-1:0]  len_d  [NNODE];
   logic [SYM_W-1:0]  sym_q  [NSYM];
   logic [SYM_W-1:0]  sym_d  [NSYM];

   logic [IDX_W-1:0]  min_a, min_b;
   logic              have_a, have_b;

   assign leaf = ptr_q[LEAF_W-1:0];

   // FSM state and pointer register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StLoad;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // FSM next state: fixed cycle counts in BUILD and ASSIGN keep latency constant
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StLoad: begin
            if (bus.in_valid) begin
               if (ptr_q == LastLeaf) begin
                  state_d = StBuild;
                  ptr_d   = FirstInt;
               end else begin
                  ptr_d = ptr_q + IDX_W'(1);
               end
            end
         end
         StBuild: begin
            if (ptr_q == Root) state_d = StAssign;
            else               ptr_d   = ptr_q + IDX_W'(1);
         end
         StAssign: begin
            if (ptr_q == FirstInt) begin
               state_d = StEmit;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q - IDX_W'(1);
            end
         end
         StEmit: begin
            if (bus.out_ready) begin
               if (ptr_q == LastLeaf) begin
                  state_d = StLoad;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + IDX_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // FSM outputs: record fields are zero outside EMIT
   always_comb begin
      bus.in_ready  = (state_q == StLoad);
      bus.out_valid = (state_q == StEmit);
      busy          = (state_q != StLoad);
      bus.out_last  = 1'b0;
      bus.out_sym   = '0;
      bus.out_code  = '0;
      bus.out_len   = '0;
      if (state_q == StEmit) begin
         bus.out_last = (ptr_q == LastLeaf);
         bus.out_sym  = sym_q[leaf];
         bus.out_code = code_q[ptr_q];
         bus.out_len  = len_q[ptr_q];
      end
   end

   // Two lightest active nodes; strict '<' in ascending order gives ties to the lower index
   always_comb begin
      min_a  = '0;
      min_b  = '0;
      have_a = 1'b0;
      have_b = 1'b0;
      for (int i = 0; i < NNODE; i++) begin
         if (act_q[i] && (!have_a || w_q[i] < w_q[min_a])) begin
            min_a  = IDX_W'(i);
            have_a = 1'b1;
         end
      end
      for (int i = 0; i < NNODE; i++) begin
         if (act_q[i] && IDX_W'(i) != min_a && (!have_b || w_q[i] < w_q[min_b])) begin
            min_b  = IDX_W'(i);
            have_b = 1'b1;
         end
      end
   end

   // Node table next state: leaf load, one merge, or code assignment per cycle
   always_comb begin
      w_d    = w_q;
      act_d  = act_q;
      par_d  = par_q;
      br_d   = br_q;
      code_d = code_q;
      len_d  = len_q;
      sym_d  = sym_q;
      unique case (state_q)
         StLoad: begin
            if (bus.in_valid) begin
               w_d[ptr_q]   = W_W'(bus.in_freq);
               act_d[ptr_q] = 1'b1;
               sym_d[leaf]  = bus.in_sym;
            end
         end
         StBuild: begin
            w_d[ptr_q]    = w_q[min_a] + w_q[min_b];
            // The root is never merged, so leave it inactive for the next block.
            act_d[ptr_q]  = (ptr_q != Root);
            code_d[ptr_q] = '0;
            len_d[ptr_q]  = '0;
            act_d[min_a]  = 1'b0;
            act_d[min_b]  = 1'b0;
            par_d[min_a]  = ptr_q;
            par_d[min_b]  = ptr_q;
            br_d[min_a]   = 1'b0;
            br_d[min_b]   = 1'b1;
         end
         StAssign: begin
            // Children always have lower indices than their parent.
            for (int j = 0; j < NNODE; j++) begin
               if (IDX_W'(j) < ptr_q && par_q[j] == ptr_q) begin
                  len_d[j]  = len_q[ptr_q] + LEN_W'(1);
                  code_d[j] = (code_q[ptr_q] << 1) | CODE_W'(br_q[j]);
               end
            end
         end
         default: ;
      endcase
   end

   // Node table storage, cleared on reset so an aborted block leaves no residue
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NNODE; i++) begin
            w_q[i]    <= '0;
            act_q[i]  <= 1'b0;
            par_q[i]  <= '0;
            br_q[i]   <= 1'b0;
            code_q[i] <= '0;
            len_q[i]  <= '0;
         end
         for (int i = 0; i < NSYM; i++) sym_q[i] <= '0;
      end else begin
         w_q    <= w_d;
         act_q  <= act_d;
         par_q  <= par_d;
         br_q   <= br_d;
         code_q <= code_d;
         len_q  <= len_d;
         sym_q  <= sym_d;
      end
   end
endmodule
